// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and FSM state encodings for the MEM-stage load/store unit
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

endpackage

// File: rtl/mem_rmw_unit_lane_op.sv
// lane_op: big-endian byte/half lane extract (with extension) and merge into a 32-bit word
module lane_op
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sgn,
    input  logic [31:0] val,
    output logic [31:0] ext,
    output logic [31:0] mrg
);

    logic [4:0]  sh;
    logic [31:0] m;
    logic [31:0] raw;
    logic        msb;

    // lane 0 sits in the top bits, so the shift is (last lane - lane) * lane width
    always_comb begin
        sh  = (size == SIZE_BYTE) ? {~lane, 3'b000} : (size == SIZE_HALF) ? {~lane[1], 4'b0000} : 5'd0;
        m   = (size == SIZE_BYTE) ? 32'h0000_00FF : (size == SIZE_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        raw = (word >> sh) & m;
        msb = (size == SIZE_BYTE) ? raw[7] : raw[15];
        ext = (sgn && msb && m != 32'hFFFF_FFFF) ? (raw | ~m) : raw;
        mrg = (word & ~(m << sh)) | ((val & m) << sh);
    end

endmodule

// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: MEM-stage load/store sequencer with read-modify-write sub-word stores
// Build option: define MEM_UNALIGNED_TRAP_EN to reject misaligned half/word accesses with resp_err
module mem_rmw_unit
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            sgn_q, sgn_d;
    logic            err_q, err_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     ext;
    logic [31:0]     mrg;
    logic [1:0]      nsize;
    logic            tmo;

`ifdef MEM_UNALIGNED_TRAP_EN
    logic            mis;
    assign mis = (nsize == SIZE_HALF && req_addr[0]) || (nsize == SIZE_WORD && req_addr[1:0] != 2'b00);
`endif

    lane_op u_lane (
        .word (mem_rdata),
        .size (size_q),
        .lane (addr_q[1:0]),
        .sgn  (sgn_q),
        .val  (wdata_q),
        .ext  (ext),
        .mrg  (mrg)
    );

    assign nsize      = (req_size == SIZE_BYTE || req_size == SIZE_HALF) ? req_size : SIZE_WORD;
    assign tmo        = (ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT - 1));
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign mem_req    = (state_q == S_RD) || (state_q == S_WR);
    assign mem_we     = (state_q == S_WR);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_q;

    // next-state: latch request, sequence RD/WR phases, count ack wait cycles
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    sgn_d   = req_signed;
                    size_d  = nsize;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    addr_d  = {req_addr[31:2], (nsize == SIZE_BYTE) ? req_addr[1:0] :
                               (nsize == SIZE_HALF) ? {req_addr[1], 1'b0} : 2'b00};
                    state_d = (req_we && nsize == SIZE_WORD) ? S_WR : S_RD;
`ifdef MEM_UNALIGNED_TRAP_EN
                    if (mis) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_RD, S_WR: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_RD && we_q) ? S_WR : S_RESP;
                    if (state_q == S_RD && we_q) wdata_d = mrg;
                    if (state_q == S_RD && !we_q) rdata_d = ext;
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
